organ_tone_gen: RTL and testbench
=================================

# organ_tone_gen

Parametrised electronic-organ core for the keyboard/buzzer board designs. Converts an N-key, one-hot-ish keypad into a square-wave tone on `beep` across multiple octaves, drives a 7-segment note digit and an octave indicator, and adds an auto-play mode that loops an internal scale sequence with beat and gap timing. Sits directly between the debounced board keys/switches and the buzzer and display pins.

## Interface
- `NUM_KEYS`, 14: number of keys; must be 7, 14, 21 or 28 (7 notes per octave, key 0 = lowest C).
- `CLK_HZ`, 1000000: `clk_in` frequency; tone table is derived from it at elaboration.
- `BEAT_CYCLES`, 250000: auto-mode beat length in `clk_in` cycles.
- `GAP_CYCLES`, 10000: silent gap at the end of each auto note; must be less than `BEAT_CYCLES`.
- Derived: `NOCT = NUM_KEYS/7`; `NW = $clog2(NUM_KEYS+1)`.

- `clk_in` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `auto` in 1: 1 = auto-play, 0 = manual keypad; asynchronous level, synchronised internally.
- `Key` in NUM_KEYS: key levels, 1 = pressed; asynchronous, synchronised internally.
- `beep` out 1: square-wave tone; 0 when silent.
- `note_idx` out NW: current note, 0 = rest, 1..NUM_KEYS = key index + 1.
- `octave` out NOCT: one-hot octave of current note; all 0 on rest.
- `codeout` out 8: active-low 7-seg `{dp,g,f,e,d,c,b,a}`.

## Operation
- Inputs `Key` and `auto` pass through 2-flop synchronisers; logic uses the synchronised values only.
- States: MANUAL, AUTO_NOTE, AUTO_GAP. Reset enters MANUAL.
- MANUAL: selected note = highest-index pressed key + 1; 0 if none pressed. Synced `auto`=1 -> AUTO_NOTE with song position 0 and beat counter 0.
- Auto song: positions 0..NUM_KEYS; position p < NUM_KEYS plays note p+1; position NUM_KEYS is a rest; then wraps to 0. Keys are ignored in auto.
- AUTO_NOTE: note = song note for `BEAT_CYCLES-GAP_CYCLES` cycles -> AUTO_GAP. AUTO_GAP: note 0 for `GAP_CYCLES` cycles -> AUTO_NOTE at next position. The rest position is silent for its entire beat.
- Synced `auto`=0 in any auto state -> MANUAL immediately; position cleared, so the next auto entry restarts at note 1.
- Tone: note n>0, digit d = ((n-1) mod 7)+1, octave k = (n-1)/7. Half-period HP = floor(base[d] >> k), base[d] = round(CLK_HZ/(2*f_d)) with f = 262,294,330,349,392,440,494 Hz. At 1 MHz base = 1908,1701,1515,1433,1276,1136,1012.
- Tone counter runs 0..HP-1; at HP-1 `beep` toggles and the counter returns to 0, so period = 2*HP cycles. When `note_idx` changes, the counter clears and `beep` goes to 0. With note 0, `beep` is held at 0.
- `codeout[6:0]`: d=1..7 -> 79,24,30,19,12,02,78 (hex, 7-bit); rest -> 3F (dash). `codeout[7]` = 0 in auto states, 1 in MANUAL.

## Timing
- Reset values: `beep`=0, `note_idx`=0, `octave`=0, `codeout`=8'hBF, state MANUAL, all counters 0.
- `Key` or `auto` edge -> registered `note_idx`, `octave`, `codeout` update 3 cycles later (2 sync + 1 register).
- The tone counter starts in the cycle `note_idx` takes its new value. The first `beep` rise follows HP cycles after that.
- The auto beat counter starts the cycle the state enters AUTO_NOTE. Note boundaries repeat exactly every `BEAT_CYCLES`.
- Asserting `rst` mid-note forces reset values asynchronously. After release, the block resumes from MANUAL; if `auto`=1, it re-enters auto at position 0 after synchronisation.
- Multiple keys pressed together: the highest index wins. Changing the key set without changing the winner causes no tone restart.

## Test plan
- Reset: hold `rst`=0 with `Key`=all 1s and `auto`=1 -> `beep`=0, `note_idx`=0, `octave`=0, `codeout`=8'hBF.
- Manual low C: `Key`=14'h0001 -> `note_idx`=1 and `codeout`=8'hF9 after 3 cycles, `octave`=2'b01, `beep` toggles every 1908 cycles.
- Octave and priority: `Key`=14'h0080 -> `note_idx`=8, HP=954, `octave`=2'b10. Then `Key`=14'h0201 -> `note_idx`=10, HP=757, `codeout`=8'hB0.
- Release: `Key`=0 while sounding -> `note_idx`=0 and `codeout`=8'hBF after 3 cycles, `beep` held 0.
- Auto with `BEAT_CYCLES`=1000, `GAP_CYCLES`=100: `auto`=1 -> notes 1..14 each for 900 cycles, each followed by 100 cycles of rest. A full 1000-cycle rest follows, then the sequence wraps to note 1. `codeout[7]`=0 throughout and key presses have no effect.
- Mode and reset mid-song: drop `auto` during note 5 -> MANUAL within 3 cycles following `Key`. Re-raise `auto` -> restarts at note 1. Pulse `rst` during auto -> reset values immediately.

Source files
------------

// File: rtl/organ_tone_gen.sv
// organ_tone_gen -- keypad / auto-play organ core driving a square-wave buzzer.
//
// Ports:
//   clk_in    system clock, all logic on the rising edge
//   rst       asynchronous active-low reset
//   auto      1 = auto-play the internal scale, 0 = manual keypad (async level)
//   Key       key levels, 1 = pressed, key 0 = lowest C (async levels)
//   beep      square-wave tone, 0 when silent
//   note_idx  0 = rest, 1..NUM_KEYS = sounding key index + 1
//   octave    one-hot octave of the current note, 0 on rest
//   codeout   active-low 7-seg {dp,g,f,e,d,c,b,a}; dp lit (0) in auto mode
module organ_tone_gen #(
  parameter  int NUM_KEYS    = 14,
  parameter  int CLK_HZ      = 1000000,
  parameter  int BEAT_CYCLES = 250000,
  parameter  int GAP_CYCLES  = 10000,
  localparam int NOCT        = NUM_KEYS / 7,
  localparam int NW          = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                auto,
  input  logic [NUM_KEYS-1:0] Key,
  output logic                beep,
  output logic [NW-1:0]       note_idx,
  output logic [NOCT-1:0]     octave,
  output logic [7:0]          codeout
);

  localparam int BW = $clog2(BEAT_CYCLES);
  localparam int OW = (NOCT > 1) ? $clog2(NOCT) : 1;
  // Low C has the longest half period, so it sizes the tone counter.
  localparam int TW = $clog2((CLK_HZ + 262) / 524 + 1);

  localparam logic [BW-1:0] NOTE_LAST = BW'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [NW-1:0] REST_POS  = NW'(NUM_KEYS);

  localparam logic [1:0] S_MANUAL = 2'd0;
  localparam logic [1:0] S_NOTE   = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  // Half period of digit d in the lowest octave: round(CLK_HZ / (2*f)).
  function automatic logic [TW-1:0] base_of(input logic [2:0] d);
    case (d)
      3'd1:    base_of = TW'((CLK_HZ + 262) / 524);
      3'd2:    base_of = TW'((CLK_HZ + 294) / 588);
      3'd3:    base_of = TW'((CLK_HZ + 330) / 660);
      3'd4:    base_of = TW'((CLK_HZ + 349) / 698);
      3'd5:    base_of = TW'((CLK_HZ + 392) / 784);
      3'd6:    base_of = TW'((CLK_HZ + 440) / 880);
      3'd7:    base_of = TW'((CLK_HZ + 494) / 988);
      default: base_of = '0;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input logic [2:0] d);
    case (d)
      3'd1:    seg_of = 7'h79;
      3'd2:    seg_of = 7'h24;
      3'd3:    seg_of = 7'h30;
      3'd4:    seg_of = 7'h19;
      3'd5:    seg_of = 7'h12;
      3'd6:    seg_of = 7'h02;
      3'd7:    seg_of = 7'h78;
      default: seg_of = 7'h3F;
    endcase
  endfunction

  // input synchronisers
  logic [NUM_KEYS-1:0] key_s1_q, key_s2_q;
  logic                auto_s1_q, auto_s2_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
    end else begin
      key_s1_q  <= Key;
      key_s2_q  <= key_s1_q;
      auto_s1_q <= auto;
      auto_s2_q <= auto_s1_q;
    end
  end

  // highest pressed key wins
  logic [NW-1:0] hi_key;
  always_comb begin
    hi_key = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (key_s2_q[i]) hi_key = NW'(i + 1);
  end

  // mode / song sequencer; one beat counter spans note and gap
  logic [1:0]    state_q, state_d;
  logic [NW-1:0] pos_q, pos_d;
  logic [BW-1:0] beat_q, beat_d;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    beat_d  = beat_q;
    case (state_q)
      S_MANUAL: begin
        if (auto_s2_q) begin
          state_d = S_NOTE;
          pos_d   = '0;
          beat_d  = '0;
        end
      end
      S_NOTE: begin
        if (beat_q == NOTE_LAST) state_d = S_GAP;
        beat_d = beat_q + 1'b1;
      end
      S_GAP: begin
        if (beat_q == BEAT_LAST) begin
          state_d = S_NOTE;
          beat_d  = '0;
          pos_d   = (pos_q == REST_POS) ? '0 : pos_q + 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = S_MANUAL;
    endcase
    if (!auto_s2_q) begin
      state_d = S_MANUAL;
      pos_d   = '0;
      beat_d  = '0;
    end
  end

  // Note and display are decoded from next-state values so they land in the
  // same cycle as the state change (2 sync flops + this register).
  logic [NW-1:0]   note_d, note_q;
  logic [2:0]      dig_d, dig_q;
  logic [OW-1:0]   oki_d, oki_q;
  logic [NOCT-1:0] oct_d, oct_q;
  logic [7:0]      code_d, code_q;

  always_comb begin
    note_d = '0;
    if (state_d == S_MANUAL)                    note_d = hi_key;
    else if (state_d == S_NOTE && pos_d != REST_POS) note_d = pos_d + 1'b1;
    dig_d = '0;
    oki_d = '0;
    oct_d = '0;
    for (int k = 0; k < NOCT; k++)
      for (int d = 1; d <= 7; d++)
        if (note_d == NW'(7 * k + d)) begin
          dig_d    = 3'(d);
          oki_d    = OW'(k);
          oct_d    = '0;
          oct_d[k] = 1'b1;
        end
    code_d = {state_d == S_MANUAL, seg_of(dig_d)};
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= S_MANUAL;
      pos_q   <= '0;
      beat_q  <= '0;
      note_q  <= '0;
      dig_q   <= '0;
      oki_q   <= '0;
      oct_q   <= '0;
      code_q  <= 8'hBF;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      beat_q  <= beat_d;
      note_q  <= note_d;
      dig_q   <= dig_d;
      oki_q   <= oki_d;
      oct_q   <= oct_d;
      code_q  <= code_d;
    end
  end

  // tone generator; a note change restarts the waveform low
  logic [TW-1:0] hp, tone_q, tone_d;
  logic          beep_q, beep_d;

  assign hp = base_of(dig_q) >> oki_q;

  always_comb begin
    tone_d = tone_q + 1'b1;
    beep_d = beep_q;
    if (note_d != note_q || note_q == '0) begin
      tone_d = '0;
      beep_d = 1'b0;
    end else if (tone_q == hp - 1'b1) begin
      tone_d = '0;
      beep_d = ~beep_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tone_q <= '0;
      beep_q <= 1'b0;
    end else begin
      tone_q <= tone_d;
      beep_q <= beep_d;
    end
  end

  assign beep     = beep_q;
  assign note_idx = note_q;
  assign octave   = oct_q;
  assign codeout  = code_q;

endmodule

// File: tb/tb_organ_tone_gen.sv
module tb_organ_tone_gen;
  localparam int NK = 14, BEAT = 1000, GAP = 100;

  logic          clk_in = 1'b0, rst = 1'b1, auto = 1'b0;
  logic [NK-1:0] Key = '0;
  logic          beep;
  logic [3:0]    note_idx;
  logic [1:0]    octave;
  logic [7:0]    codeout;

  organ_tone_gen #(.NUM_KEYS(NK), .CLK_HZ(1000000), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk_in(clk_in), .rst(rst), .auto(auto), .Key(Key),
    .beep(beep), .note_idx(note_idx), .octave(octave), .codeout(codeout));

  always #5 clk_in = ~clk_in;

  int total = 0, bad = 0, cyc = 0;
  bit [NK-1:0] kh [0:65535];
  bit          ah [0:65535];
  int seg  [1:7] = '{'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78};
  int base [1:7] = '{1908, 1701, 1515, 1433, 1276, 1136, 1012};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference: outputs follow inputs applied 3 cycles earlier; auto timing is
  // measured from the cycle auto mode was entered; beep from the last note change.
  int t0 = 0, tc = 0, pn = 0;
  bit ap = 0;
  always @(negedge clk_in) begin
    int n, d, k, j, p, hpv, en_beep, en_oct, en_code;
    bit ae, dp;
    bit [NK-1:0] ke;
    if (!rst) begin
      pn = 0; ap = 0;
      chk("rst_beep", beep, 0);
      chk("rst_note", note_idx, 0);
      chk("rst_oct", octave, 0);
      chk("rst_code", codeout, 8'hBF);
    end else begin
      ae = (cyc >= 3) ? ah[cyc-3] : 1'b0;
      ke = (cyc >= 3) ? kh[cyc-3] : '0;
      if (ae && !ap) t0 = cyc;
      ap = ae;
      n = 0;
      if (ae) begin
        j = cyc - t0;
        p = (j / BEAT) % (NK + 1);
        if (p < NK && (j % BEAT) < BEAT - GAP) n = p + 1;
      end else begin
        for (int i = 0; i < NK; i++) if (ke[i]) n = i + 1;
      end
      if (n != pn) tc = cyc;
      pn = n;
      dp = !ae;
      if (n == 0) begin
        en_beep = 0; en_oct = 0; en_code = {dp, 7'h3F};
      end else begin
        d = (n - 1) % 7 + 1;
        k = (n - 1) / 7;
        hpv = base[d] >> k;
        en_beep = ((cyc - tc) / hpv) % 2;
        en_oct = 1 << k;
        en_code = {dp, seg[d][6:0]};
      end
      chk("note", note_idx, n);
      chk("beep", beep, en_beep);
      chk("octave", octave, en_oct);
      chk("codeout", codeout, en_code);
    end
  end

  task automatic step(input logic [NK-1:0] k, input logic a, input logic r);
    @(posedge clk_in);
    #1;
    rst = r; Key = k; auto = a;
    kh[cyc] = r ? k : '0;
    ah[cyc] = r ? a : 1'b0;
  endtask

  task automatic hold(input logic [NK-1:0] k, input logic a, input int n);
    repeat (n) step(k, a, 1'b1);
  endtask

  task automatic rst_pulse(input logic a);
    @(posedge clk_in);
    #3 rst = 1'b0;
    #1;
    chk("async_beep", beep, 0);
    chk("async_note", note_idx, 0);
    chk("async_oct", octave, 0);
    chk("async_code", codeout, 8'hBF);
    repeat (4) step('1, a, 1'b0);
    step('0, a, 1'b1);
  endtask

  initial begin
    logic [NK-1:0] k, low;
    int msb;
    Key = '1; auto = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("init_beep", beep, 0);
    chk("init_note", note_idx, 0);
    chk("init_code", codeout, 8'hBF);
    repeat (5) step('1, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    hold('0, 0, 10);
    // directed manual patterns
    hold(14'h0001, 0, 4000);
    hold(14'h0080, 0, 2500);
    hold(14'h0201, 0, 2000);
    hold(14'h0000, 0, 100);
    // random manual, including winner-preserving key-set changes
    for (int it = 0; it < 16; it++) begin
      k = NK'($urandom) >> $urandom_range(0, NK - 1);
      hold(k, 0, $urandom_range(5, 1200));
      if (k != 0) begin
        msb = 0;
        for (int i = 0; i < NK; i++) if (k[i]) msb = i;
        low = NK'($urandom) & ((NK'(1) << msb) - 1'b1);
        hold((NK'(1) << msb) | low, 0, $urandom_range(50, 800));
      end
    end
    // auto: full song plus wrap, keys toggling randomly
    for (int i = 0; i < 16200 / 50; i++) hold(NK'($urandom), 1, 50);
    hold('0, 0, 20);
    // auto again, drop during note 5, manual keys, re-enter
    hold(14'h0004, 1, 4500);
    hold(14'h0004, 0, 40);
    hold(14'h0100, 0, 30);
    hold(14'h0100, 1, 2500);
    rst_pulse(1'b1);
    hold(14'h0010, 1, 3000);
    hold('0, 0, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
